// File: rtl/shift_register_with_valid_ready.sv
// DEPTH-stage, WIDTH-bit delay line with valid/ready handshake, bubble collapse and synchronous flush.
// Define SHIFT_REGISTER_WITH_VALID_READY_COUNT_EN to add the registered occupancy output `count`.
module shift_register_with_valid_ready #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        in_vld,
    output logic                        in_rdy,
    input  logic [WIDTH-1:0]            in_data,
    output logic                        out_vld,
    input  logic                        out_rdy,
    output logic [WIDTH-1:0]            out_data
`ifdef SHIFT_REGISTER_WITH_VALID_READY_COUNT_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0]  count
`endif
);

    logic [DEPTH-1:0] vld;
    logic [WIDTH-1:0] dat     [DEPTH];
    logic [DEPTH-1:0] adv;
    logic [DEPTH-1:0] src_vld;
    logic [WIDTH-1:0] src_dat [DEPTH];

    // A stage may advance when out_rdy is high or any stage from it to the tail is empty;
    // this is the unrolled form of adv[i] = !vld[i] || adv[i+1].
    always_comb begin : ready_chain
        logic all_full;
        all_full = 1'b1;
        adv      = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            all_full = all_full & vld[i];
            adv[i]   = out_rdy | ~all_full;
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_src
        if (i == 0) begin : g_head
            assign src_vld[i] = in_vld;
            assign src_dat[i] = in_data;
        end else begin : g_body
            assign src_vld[i] = vld[i-1];
            assign src_dat[i] = dat[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            vld <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (adv[i]) vld[i] <= src_vld[i];
            end
        end
    end

    // Data is only captured with a valid word and is never cleared.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (adv[i] && src_vld[i]) dat[i] <= src_dat[i];
        end
    end

    assign in_rdy   = adv[0];
    assign out_vld  = vld[DEPTH-1];
    assign out_data = dat[DEPTH-1];

`ifdef SHIFT_REGISTER_WITH_VALID_READY_COUNT_EN
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic in_xfer;
    logic out_xfer;

    assign in_xfer  = in_vld & in_rdy;
    assign out_xfer = out_vld & out_rdy;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            count <= '0;
        end else if (in_xfer && !out_xfer) begin
            count <= count + CNT_W'(1);
        end else if (!in_xfer && out_xfer) begin
            count <= count - CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_shift_register_with_valid_ready.sv
// Scoreboard bench for shift_register_with_valid_ready: directed DEPTH=8 vectors plus a DEPTH=1/WIDTH=1 random run.
// Count checks are active when SHIFT_REGISTER_WITH_VALID_READY_COUNT_EN is defined.
module tb_shift_register_with_valid_ready;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, flush;
    logic       in_vld, in_rdy, out_vld, out_rdy;
    logic [7:0] in_data, out_data;
    logic       flush1;
    logic       in_vld1, in_rdy1, out_vld1, out_rdy1;
    logic [0:0] in_data1, out_data1;
`ifdef SHIFT_REGISTER_WITH_VALID_READY_COUNT_EN
    logic [3:0] count8;
    logic [0:0] count1;
`endif

    int         n_cmp = 0;
    int         n_fail = 0;
    logic [7:0] q8[$];
    logic [0:0] q1[$];

    shift_register_with_valid_ready #(.WIDTH(8), .DEPTH(8)) dut8 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_vld(in_vld), .in_rdy(in_rdy), .in_data(in_data),
        .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data)
`ifdef SHIFT_REGISTER_WITH_VALID_READY_COUNT_EN
        , .count(count8)
`endif
    );

    shift_register_with_valid_ready #(.WIDTH(1), .DEPTH(1)) dut1 (
        .clk(clk), .rst(rst), .flush(flush1),
        .in_vld(in_vld1), .in_rdy(in_rdy1), .in_data(in_data1),
        .out_vld(out_vld1), .out_rdy(out_rdy1), .out_data(out_data1)
`ifdef SHIFT_REGISTER_WITH_VALID_READY_COUNT_EN
        , .count(count1)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of dut8 inputs; an accepted word becomes an expected output.
    task automatic drive8(input logic v, input logic [7:0] d, input logic ordy);
        in_vld  = v;
        in_data = d;
        out_rdy = ordy;
        #1;
        if (v && in_rdy && !rst && !flush) q8.push_back(d);
    endtask

    always @(negedge clk) begin
        if (out_vld === 1'b1 && out_rdy === 1'b1) begin
            if (q8.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL out8_unexpected: got %0h, required no output", out_data);
            end else begin
                chk("out8_data", 32'(out_data), 32'(q8.pop_front()));
            end
        end
    end

    always @(negedge clk) begin
        if (out_vld1 === 1'b1 && out_rdy1 === 1'b1) begin
            if (q1.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL out1_unexpected: got %0h, required no output", out_data1);
            end else begin
                chk("out1_data", 32'(out_data1), 32'(q1.pop_front()));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        rst = 1'b1; flush = 1'b0; flush1 = 1'b0;
        in_vld = 1'b1; in_data = 8'hEE; out_rdy = 1'b0;
        in_vld1 = 1'b1; in_data1 = 1'b1; out_rdy1 = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        in_vld = 1'b0; in_vld1 = 1'b0;
        #1;
        chk("rst_out_vld", 32'(out_vld), 0);
        chk("rst_in_rdy", 32'(in_rdy), 1);
`ifdef SHIFT_REGISTER_WITH_VALID_READY_COUNT_EN
        chk("rst_count", 32'(count8), 0);
`endif
        fork
            begin
                for (int k = 0; k < 12; k++) begin
                    drive8(1'b0, 8'h00, 1'b1);
                    tick();
                end
                chk("idle_out_vld", 32'(out_vld), 0);

                // free flow 0x01..0x10
                for (int k = 0; k < 24; k++) begin
                    drive8(k < 16, 8'(k + 1), 1'b1);
                    if (k < 16) chk("ff_in_rdy", 32'(in_rdy), 1);
                    chk("ff_out_vld", 32'(out_vld), 32'(k >= 8));
                    tick();
                end
                drive8(1'b0, 8'h00, 1'b1);
                chk("ff_end_vld", 32'(out_vld), 0);
                chk("ff_empty", 32'(q8.size()), 0);
                tick();

                // fill under stall
                acc = 0;
                for (int k = 0; k < 13; k++) begin
                    drive8(1'b1, 8'(8'hA0 + acc), 1'b0);
                    chk("fill_in_rdy", 32'(in_rdy), 32'(k < 8));
                    if (in_rdy) acc++;
                    if (k >= 8) begin
                        chk("fill_hold_vld", 32'(out_vld), 1);
                        chk("fill_hold_data", 32'(out_data), 32'hA0);
                    end
                    tick();
                end
`ifdef SHIFT_REGISTER_WITH_VALID_READY_COUNT_EN
                chk("fill_count", 32'(count8), 8);
`endif
                drive8(1'b1, 8'hA8, 1'b1);
                chk("fill_swap_rdy", 32'(in_rdy), 1);
                chk("fill_swap_vld", 32'(out_vld), 1);
                chk("fill_swap_data", 32'(out_data), 32'hA0);
                tick();
                for (int k = 0; k < 10; k++) begin
                    drive8(1'b0, 8'h00, 1'b1);
                    tick();
                end
                chk("fill_empty", 32'(q8.size()), 0);

                // bubble collapse
                drive8(1'b1, 8'h11, 1'b0);
                chk("bub_rdy0", 32'(in_rdy), 1);
                tick();
                for (int k = 0; k < 3; k++) begin
                    drive8(1'b0, 8'h00, 1'b0);
                    tick();
                end
                drive8(1'b1, 8'h22, 1'b0);
                chk("bub_rdy1", 32'(in_rdy), 1);
                tick();
                for (int k = 0; k < 10; k++) begin
                    drive8(1'b0, 8'h00, 1'b0);
                    tick();
                end
                drive8(1'b0, 8'h00, 1'b0);
                chk("bub_in_rdy", 32'(in_rdy), 1);
                chk("bub_out_vld", 32'(out_vld), 1);
                chk("bub_head", 32'(out_data), 32'h11);
`ifdef SHIFT_REGISTER_WITH_VALID_READY_COUNT_EN
                chk("bub_count", 32'(count8), 2);
`endif
                tick();
                drive8(1'b0, 8'h00, 1'b1);
                chk("bub_o1_vld", 32'(out_vld), 1);
                chk("bub_o1_data", 32'(out_data), 32'h11);
                tick();
                drive8(1'b0, 8'h00, 1'b1);
                chk("bub_o2_vld", 32'(out_vld), 1);
                chk("bub_o2_data", 32'(out_data), 32'h22);
                tick();
                drive8(1'b0, 8'h00, 1'b1);
                chk("bub_o3_vld", 32'(out_vld), 0);
                tick();

                // flush mid-stream
                for (int k = 0; k < 5; k++) begin
                    drive8(1'b1, 8'(8'h31 + k), 1'b0);
                    tick();
                end
                in_vld = 1'b1; in_data = 8'h55; out_rdy = 1'b0; flush = 1'b1;
                q8.delete();
                tick();
                flush = 1'b0;
                drive8(1'b0, 8'h00, 1'b0);
                chk("fl_out_vld", 32'(out_vld), 0);
                chk("fl_in_rdy", 32'(in_rdy), 1);
`ifdef SHIFT_REGISTER_WITH_VALID_READY_COUNT_EN
                chk("fl_count", 32'(count8), 0);
`endif
                tick();
                for (int k = 0; k < 10; k++) begin
                    drive8(k == 0, 8'h66, 1'b1);
                    chk("fl_66_vld", 32'(out_vld), 32'(k == 8));
                    tick();
                end
                chk("fl_empty", 32'(q8.size()), 0);
            end
            begin
                for (int k = 0; k < 10000; k++) begin
`ifdef SHIFT_REGISTER_WITH_VALID_READY_COUNT_EN
                    chk("d1_count", 32'(count1), 32'(q1.size()));
`endif
                    in_vld1  = 1'($urandom_range(0, 1));
                    in_data1 = 1'($urandom_range(0, 1));
                    out_rdy1 = 1'($urandom_range(0, 1));
                    #1;
                    if (in_vld1 && in_rdy1) q1.push_back(in_data1);
                    tick();
                end
                in_vld1  = 1'b0;
                out_rdy1 = 1'b1;
                for (int k = 0; k < 3; k++) tick();
                chk("d1_empty", 32'(q1.size()), 0);
            end
        join
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
